alpha_blend_stage: RTL and testbench

ALPHA_BLEND_STAGE -- requirements
Module: alpha_blend_stage

---
 rtl/alpha_blend_stage.sv | 160 ++++++++++++++++
 tb/tb_alpha_blend_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alpha_blend_stage.sv
// Texel-over-framebuffer alpha blend stage: read-modify-write of one pixel every
// four cycles, with a frame-complete handshake toward the output controller.
module alpha_blend_stage #(
  parameter int MAX_PIXEL = 76799
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tex_valid,
  output logic        tex_ready,
  input  logic [7:0]  tex_r,
  input  logic [7:0]  tex_g,
  input  logic [7:0]  tex_b,
  input  logic [7:0]  tex_alpha,
  input  logic [16:0] tex_pixel,
  input  logic        tex_last,
  output logic [16:0] fb_pixel,
  input  logic [7:0]  fb_read_r,
  input  logic [7:0]  fb_read_g,
  input  logic [7:0]  fb_read_b,
  output logic [7:0]  write_r,
  output logic [7:0]  write_g,
  output logic [7:0]  write_b,
  output logic        fb_write,
  output logic        frame_ready,
  input  logic        frame_done,
  output logic [16:0] blend_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    BLEND = 3'd2,
    WRITE = 3'd3,
    FRAME = 3'd4,
    DRAIN = 3'd5
  } state_e;

  localparam logic [16:0] MAX_PIX   = 17'(MAX_PIXEL);
  localparam logic [16:0] COUNT_MAX = 17'h1FFFF;

  // Folding bit 7 back in maps 255 to 256 so opaque texels pass through exactly.
  function automatic logic [8:0] alpha_scale(input logic [7:0] a);
    return {1'b0, a} + {8'd0, a[7]};
  endfunction

  function automatic logic [7:0] blend_ch(input logic [7:0] src, input logic [7:0] dst,
                                          input logic [8:0] a);
    logic [16:0] sum;
    sum = 17'(src) * 17'(a) + 17'(dst) * 17'(9'd256 - a);
    return 8'(sum >> 8);
  endfunction

  state_e      state_q;
  logic        tex_ready_q;
  logic        fb_write_q;
  logic        frame_ready_q;
  logic [7:0]  write_r_q, write_g_q, write_b_q;
  logic [16:0] blend_count_q;
  logic [7:0]  src_r_q, src_g_q, src_b_q, alpha_q;
  logic [16:0] pix_q;
  logic        last_q;

  logic [8:0]  alpha_s;
  logic [7:0]  blend_r_d, blend_g_d, blend_b_d;
  logic        in_range_s;
  logic [16:0] fb_pixel_s;

  always_comb begin
    alpha_s    = alpha_scale(alpha_q);
    blend_r_d  = blend_ch(src_r_q, fb_read_r, alpha_s);
    blend_g_d  = blend_ch(src_g_q, fb_read_g, alpha_s);
    blend_b_d  = blend_ch(src_b_q, fb_read_b, alpha_s);
    in_range_s = (pix_q <= MAX_PIX);
    // In IDLE the RAM address tracks the incoming texel so read data is ready by BLEND.
    fb_pixel_s = (state_q == IDLE) ? tex_pixel : pix_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      tex_ready_q   <= 1'b0;
      fb_write_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      write_r_q     <= 8'd0;
      write_g_q     <= 8'd0;
      write_b_q     <= 8'd0;
      blend_count_q <= 17'd0;
      src_r_q       <= 8'd0;
      src_g_q       <= 8'd0;
      src_b_q       <= 8'd0;
      alpha_q       <= 8'd0;
      pix_q         <= 17'd0;
      last_q        <= 1'b0;
    end else begin
      fb_write_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tex_valid && tex_ready_q) begin
            src_r_q     <= tex_r;
            src_g_q     <= tex_g;
            src_b_q     <= tex_b;
            alpha_q     <= tex_alpha;
            pix_q       <= tex_pixel;
            last_q      <= tex_last;
            tex_ready_q <= 1'b0;
            state_q     <= READ;
          end else begin
            tex_ready_q <= 1'b1;
          end
        end
        READ: state_q <= BLEND;
        BLEND: begin
          write_r_q <= blend_r_d;
          write_g_q <= blend_g_d;
          write_b_q <= blend_b_d;
          // Out-of-frame texels still walk the pipeline but never reach memory.
          if (in_range_s) begin
            fb_write_q <= 1'b1;
            if (blend_count_q != COUNT_MAX) begin
              blend_count_q <= blend_count_q + 17'd1;
            end
          end
          state_q <= WRITE;
        end
        WRITE: begin
          if (last_q) begin
            frame_ready_q <= 1'b1;
            state_q       <= FRAME;
          end else begin
            tex_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        FRAME: state_q <= DRAIN;
        DRAIN: begin
          if (frame_done) begin
            blend_count_q <= 17'd0;
            tex_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          tex_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign tex_ready   = tex_ready_q;
  assign fb_pixel    = fb_pixel_s;
  assign write_r     = write_r_q;
  assign write_g     = write_g_q;
  assign write_b     = write_b_q;
  assign fb_write    = fb_write_q;
  assign frame_ready = frame_ready_q;
  assign blend_count = blend_count_q;

endmodule

// File: tb/tb_alpha_blend_stage.sv
// Directed bench for alpha_blend_stage: blend arithmetic, pipeline timing,
// frame handshake, out-of-range drop and reset abort.
module tb_alpha_blend_stage;

  logic        clk;
  logic        reset;
  logic        tex_valid;
  logic        tex_ready;
  logic [7:0]  tex_r, tex_g, tex_b, tex_alpha;
  logic [16:0] tex_pixel;
  logic        tex_last;
  logic [16:0] fb_pixel;
  logic [7:0]  fb_read_r, fb_read_g, fb_read_b;
  logic [7:0]  write_r, write_g, write_b;
  logic        fb_write;
  logic        frame_ready;
  logic        frame_done;
  logic [16:0] blend_count;

  int checks;
  int failures;

  alpha_blend_stage #(.MAX_PIXEL(76799)) dut (
    .clk(clk), .reset(reset), .tex_valid(tex_valid), .tex_ready(tex_ready),
    .tex_r(tex_r), .tex_g(tex_g), .tex_b(tex_b), .tex_alpha(tex_alpha),
    .tex_pixel(tex_pixel), .tex_last(tex_last), .fb_pixel(fb_pixel),
    .fb_read_r(fb_read_r), .fb_read_g(fb_read_g), .fb_read_b(fb_read_b),
    .write_r(write_r), .write_g(write_g), .write_b(write_b),
    .fb_write(fb_write), .frame_ready(frame_ready), .frame_done(frame_done),
    .blend_count(blend_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_tex(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [7:0] a, input logic [16:0] p, input logic l);
    tex_valid = 1'b1;
    tex_r = r; tex_g = g; tex_b = b; tex_alpha = a; tex_pixel = p; tex_last = l;
  endtask

  task automatic set_fb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    fb_read_r = r; fb_read_g = g; fb_read_b = b;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    tex_valid = 1'b0;
    tex_r = 8'd0; tex_g = 8'd0; tex_b = 8'd0; tex_alpha = 8'd0;
    tex_pixel = 17'd0; tex_last = 1'b0; frame_done = 1'b0;
    set_fb(8'd0, 8'd0, 8'd0);

    // Reset state
    tick(); tick();
    chk("rst_tex_ready", 32'(tex_ready), 32'd0);
    chk("rst_fb_write", 32'(fb_write), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_write", 32'({write_r, write_g, write_b}), 32'd0);
    chk("rst_count", 32'(blend_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(tex_ready), 32'd1);

    // Opaque texel: write equals source, 3 cycles after accept
    set_tex(8'd200, 8'd100, 8'd50, 8'd255, 17'd5, 1'b0);
    #1;
    chk("idle_fb_pixel_follow", 32'(fb_pixel), 32'd5);
    tick();
    tex_valid = 1'b0;
    tex_pixel = 17'd99;
    #1;
    chk("read_ready_low", 32'(tex_ready), 32'd0);
    chk("read_fb_pixel_hold", 32'(fb_pixel), 32'd5);
    tick();
    chk("blend_no_write", 32'(fb_write), 32'd0);
    tick();
    chk("opaque_fb_write", 32'(fb_write), 32'd1);
    chk("opaque_fb_pixel", 32'(fb_pixel), 32'd5);
    chk("opaque_write", 32'({write_r, write_g, write_b}), 32'({8'd200, 8'd100, 8'd50}));
    chk("opaque_count", 32'(blend_count), 32'd1);
    tick();
    chk("after_write_strobe", 32'(fb_write), 32'd0);
    chk("after_write_ready", 32'(tex_ready), 32'd1);

    // Transparent texel: write equals framebuffer
    set_tex(8'd255, 8'd255, 8'd255, 8'd0, 17'd7, 1'b0);
    set_fb(8'd10, 8'd20, 8'd30);
    tick(); tex_valid = 1'b0;
    tick(); tick();
    chk("transp_write", 32'({write_r, write_g, write_b}), 32'({8'd10, 8'd20, 8'd30}));
    chk("transp_count", 32'(blend_count), 32'd2);
    tick();

    // Half alpha: 255*129>>8 = 128
    set_tex(8'd255, 8'd255, 8'd255, 8'd128, 17'd9, 1'b0);
    set_fb(8'd0, 8'd0, 8'd0);
    tick(); tex_valid = 1'b0;
    tick(); tick();
    chk("half_write", 32'({write_r, write_g, write_b}), 32'({8'd128, 8'd128, 8'd128}));
    tick();

    // alpha 64: (200*64+100*192)>>8=125, (255*192)>>8=191, (255*64)>>8=63
    set_tex(8'd200, 8'd0, 8'd255, 8'd64, 17'd10, 1'b0);
    set_fb(8'd100, 8'd255, 8'd0);
    tick(); tex_valid = 1'b0;
    tick(); tick();
    chk("mix_write", 32'({write_r, write_g, write_b}), 32'({8'd125, 8'd191, 8'd63}));
    chk("mix_count", 32'(blend_count), 32'd4);
    tick();

    // frame_done ignored in IDLE and in BLEND
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("fd_idle_ready", 32'(tex_ready), 32'd1);
    chk("fd_idle_count", 32'(blend_count), 32'd4);
    set_tex(8'd1, 8'd2, 8'd3, 8'd255, 17'd11, 1'b0);
    tick(); tex_valid = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("fd_blend_write", 32'(fb_write), 32'd1);
    chk("fd_blend_count", 32'(blend_count), 32'd5);
    tick();
    chk("fd_blend_back_idle", 32'(tex_ready), 32'd1);

    // Out-of-range last texel: dropped, frame still closes
    set_tex(8'd7, 8'd7, 8'd7, 8'd255, 17'd76800, 1'b1);
    tick(); tex_valid = 1'b0;
    tick(); tick();
    chk("oor_no_write", 32'(fb_write), 32'd0);
    chk("oor_count", 32'(blend_count), 32'd5);
    tick();
    chk("oor_frame_ready", 32'(frame_ready), 32'd1);
    chk("oor_frame_tex_ready", 32'(tex_ready), 32'd0);
    tick();
    chk("oor_frame_ready_pulse", 32'(frame_ready), 32'd0);
    tick(); tick();
    chk("oor_drain_hold", 32'(tex_ready), 32'd0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("oor_done_ready", 32'(tex_ready), 32'd1);
    chk("oor_done_count", 32'(blend_count), 32'd0);

    // Stream of 3 texels with tex_valid held high, last on the third
    set_fb(8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      set_tex(8'(i + 1), 8'd0, 8'd0, 8'd255, 17'(20 + i), (i == 2));
      chk("stream_ready_high", 32'(tex_ready), 32'd1);
      tick();
      chk("stream_ready_low", 32'(tex_ready), 32'd0);
      tick(); tick();
      chk("stream_write", 32'(fb_write), 32'd1);
      chk("stream_write_r", 32'(write_r), 32'(i + 1));
      chk("stream_count", 32'(blend_count), 32'(i + 1));
      tick();
    end
    chk("stream_frame_ready", 32'(frame_ready), 32'd1);
    chk("stream_frame_count", 32'(blend_count), 32'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stream_drain_no_pulse", 32'(frame_ready), 32'd0);
      chk("stream_drain_ready", 32'(tex_ready), 32'd0);
    end
    tex_valid = 1'b0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("stream_done_ready", 32'(tex_ready), 32'd1);
    chk("stream_done_count", 32'(blend_count), 32'd0);

    // Reset during WRITE aborts the texel and the frame
    set_tex(8'd9, 8'd9, 8'd9, 8'd255, 17'd30, 1'b1);
    tick(); tex_valid = 1'b0;
    tick(); tick();
    chk("abort_pre_write", 32'(fb_write), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_fb_write", 32'(fb_write), 32'd0);
    chk("abort_write", 32'({write_r, write_g, write_b}), 32'd0);
    chk("abort_count", 32'(blend_count), 32'd0);
    chk("abort_ready", 32'(tex_ready), 32'd0);
    chk("abort_frame_ready", 32'(frame_ready), 32'd0);
    tick();
    chk("abort_ready_after", 32'(tex_ready), 32'd1);
    chk("abort_no_frame", 32'(frame_ready), 32'd0);
    tick();
    chk("abort_idle_no_write", 32'(fb_write), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
